residual_add_9bit: RTL and testbench

Element-wise residual (skip-connection) adder directly upstream of the 9-bit requantize stage. It buffers SIZE-lane signed 8-bit skip-path pixel vectors in an internal FIFO. When the matching main-path vector arrives, the two are added lane by lane into signed 9-bit sums. The registered 9-bit vector plus a valid strobe feed the requantize stage's 9*SIZE-bit input, which has no backpressure.

---
 rtl/residual_add_9bit_pkg.sv | 12 +
 rtl/residual_add_9bit_if.sv | 30 +++
 rtl/residual_add_9bit_sync_fifo.sv | 49 ++++
 rtl/residual_add_9bit.sv | 60 ++++++
 tb/tb_residual_add_9bit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/residual_add_9bit_pkg.sv
// Shared layer constants for the residual-add / requantize datapath.
package residual_add_9bit_pkg;

    localparam int unsigned PIXEL_W = 8;
    localparam int unsigned SUM_W   = 9;

    // Sign-extend one pixel lane to the sum width.
    function automatic logic signed [SUM_W-1:0] widen(input logic [PIXEL_W-1:0] p);
        return {p[PIXEL_W-1], p};
    endfunction

endpackage

// File: rtl/residual_add_9bit_if.sv
// Skip/main input handshakes and the registered sum output of residual_add_9bit.
interface residual_add_9bit_if
    import residual_add_9bit_pkg::*;
#(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic                      skip_valid;
    logic                      skip_ready;
    logic [PIXEL_W*SIZE-1:0]   skip_in;
    logic                      main_valid;
    logic                      main_ready;
    logic [PIXEL_W*SIZE-1:0]   main_in;
    logic                      sum_valid;
    logic [SUM_W*SIZE-1:0]     sum_out;
    logic [PTR_W:0]            fifo_count;

    modport master (
        output skip_valid, skip_in, main_valid, main_in,
        input  skip_ready, main_ready, sum_valid, sum_out, fifo_count
    );

    modport slave (
        input  skip_valid, skip_in, main_valid, main_in,
        output skip_ready, main_ready, sum_valid, sum_out, fifo_count
    );

endinterface

// File: rtl/residual_add_9bit_sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/residual_add_9bit.sv
// Residual adder: buffers skip vectors, adds each to the matching main vector
// lane by lane and registers the 9-bit sums for the requantize stage.
module residual_add_9bit
    import residual_add_9bit_pkg::*;
#(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    residual_add_9bit_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned WIDTH = PIXEL_W * SIZE;

    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [WIDTH-1:0]        head;
    logic [PTR_W:0]          count;
    logic [SUM_W*SIZE-1:0]   sums;

    assign bus.skip_ready = !full;
    assign bus.main_ready = !empty;
    assign bus.fifo_count = count;
    assign push           = bus.skip_valid && !full;
    assign pop            = bus.main_valid && !empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.skip_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        assign sums[SUM_W*i +: SUM_W] = widen(head[PIXEL_W*i +: PIXEL_W])
                                      + widen(bus.main_in[PIXEL_W*i +: PIXEL_W]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.sum_valid <= 1'b0;
            bus.sum_out   <= '0;
        end else begin
            bus.sum_valid <= pop;
            if (pop) bus.sum_out <= sums;
        end
    end

endmodule

// File: tb/tb_residual_add_9bit.sv
// Randomized self-checking bench for residual_add_9bit against a queue-based model.
module tb_residual_add_9bit;
    import residual_add_9bit_pkg::*;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned VW    = 8 * SIZE;
    localparam int unsigned SW    = 9 * SIZE;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    residual_add_9bit_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

    residual_add_9bit #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests_run = 0;
    int fails     = 0;

    logic [VW-1:0] skip_q[$];
    logic          exp_valid = 1'b0;
    logic [SW-1:0] exp_sum   = '0;
    bit            last_push;
    bit            last_pop;

    function automatic logic [SW-1:0] ref_sum(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [SW-1:0] r;
        int x, y, s;
        for (int i = 0; i < SIZE; i++) begin
            x = $signed(a[8*i +: 8]);
            y = $signed(b[8*i +: 8]);
            s = x + y;
            r[9*i +: 9] = s[8:0];
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom};
    endfunction

    // Advance the model with the inputs currently driven, then one clock.
    task automatic tick();
        if (!reset) begin
            skip_q.delete();
            exp_valid = 1'b0;
            exp_sum   = '0;
            last_push = 1'b0;
            last_pop  = 1'b0;
        end else begin
            last_pop  = bus.main_valid && (skip_q.size() != 0);
            last_push = bus.skip_valid && (skip_q.size() != DEPTH);
            exp_valid = last_pop;
            if (last_pop)  exp_sum = ref_sum(skip_q.pop_front(), bus.main_in);
            if (last_push) skip_q.push_back(bus.skip_in);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        tests_run++; if (bus.fifo_count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
        tests_run++; if (bus.skip_ready !== 1'b1) begin fails++; $display("FAIL reset_skip_ready: got %b expected 1", bus.skip_ready); end
        tests_run++; if (bus.main_ready !== 1'b0) begin fails++; $display("FAIL reset_main_ready: got %b expected 0", bus.main_ready); end
        tests_run++; if (bus.sum_valid !== 1'b0) begin fails++; $display("FAIL reset_sum_valid: got %b expected 0", bus.sum_valid); end
        tests_run++; if (bus.sum_out !== '0) begin fails++; $display("FAIL reset_sum_out: got %h expected 0", bus.sum_out); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [VW-1:0] s, m;
        s = rand_vec(); s[7:0] = 8'h7F;
        m = rand_vec(); m[7:0] = 8'h7F;
        bus.skip_in = s; bus.skip_valid = 1'b1;
        tick();
        bus.skip_valid = 1'b0;
        bus.main_in = m; bus.main_valid = 1'b1;
        tick();
        bus.main_valid = 1'b0;
        tests_run++; if (bus.sum_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", bus.sum_valid); end
        tests_run++; if (bus.sum_out[8:0] !== 9'h0FE) begin fails++; $display("FAIL single_lane0: got %h expected 0fe", bus.sum_out[8:0]); end
        tests_run++; if (bus.sum_out !== exp_sum) begin fails++; $display("FAIL single_vec: got %h expected %h", bus.sum_out, exp_sum); end
        tick();
        tests_run++; if (bus.sum_valid !== 1'b0) begin fails++; $display("FAIL single_strobe: got %b expected 0", bus.sum_valid); end
        tests_run++; if (bus.sum_out !== exp_sum) begin fails++; $display("FAIL single_hold: got %h expected %h", bus.sum_out, exp_sum); end
    endtask

    task automatic test_extremes();
        logic [SW-1:0] want;
        bus.skip_in = {SIZE{8'h80}}; bus.skip_valid = 1'b1;
        tick();
        bus.skip_in = {SIZE{8'h05}};
        bus.main_in = {SIZE{8'h80}}; bus.main_valid = 1'b1;
        tick();
        bus.skip_valid = 1'b0;
        want = {SIZE{9'h100}};
        tests_run++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== want) begin fails++; $display("FAIL min_sum: got %b/%h expected 1/%h", bus.sum_valid, bus.sum_out, want); end
        bus.main_in = {SIZE{8'hFB}};
        tick();
        bus.main_valid = 1'b0;
        tests_run++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== '0) begin fails++; $display("FAIL zero_sum: got %b/%h expected 1/0", bus.sum_valid, bus.sum_out); end
        tick();
        tests_run++; if (bus.fifo_count !== '0) begin fails++; $display("FAIL extremes_drain: got %0d expected 0", bus.fifo_count); end
    endtask

    task automatic test_main_before_skip();
        bus.main_in = rand_vec(); bus.main_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (bus.main_ready !== 1'b0 || bus.sum_valid !== 1'b0) begin fails++; $display("FAIL early_main: got ready=%b valid=%b expected 0/0", bus.main_ready, bus.sum_valid); end
        end
        bus.skip_in = rand_vec(); bus.skip_valid = 1'b1;
        tick();
        bus.skip_valid = 1'b0;
        tests_run++; if (bus.main_ready !== 1'b1 || bus.sum_valid !== 1'b0) begin fails++; $display("FAIL nobypass: got ready=%b valid=%b expected 1/0", bus.main_ready, bus.sum_valid); end
        tick();
        bus.main_valid = 1'b0;
        tests_run++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== exp_sum) begin fails++; $display("FAIL late_pair: got %b/%h expected 1/%h", bus.sum_valid, bus.sum_out, exp_sum); end
        tick();
    endtask

    task automatic test_full();
        bus.skip_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.skip_in = rand_vec();
            tick();
        end
        tests_run++; if (bus.fifo_count !== 5'd16 || bus.skip_ready !== 1'b0) begin fails++; $display("FAIL full: got count=%0d ready=%b expected 16/0", bus.fifo_count, bus.skip_ready); end
        bus.skip_in = rand_vec();
        tick();
        tick();
        tests_run++; if (bus.fifo_count !== 5'd16) begin fails++; $display("FAIL full_hold: got %0d expected 16", bus.fifo_count); end
        bus.main_in = rand_vec(); bus.main_valid = 1'b1;
        tick();
        bus.skip_valid = 1'b0;
        tests_run++; if (bus.fifo_count !== 5'd15 || bus.skip_ready !== 1'b1) begin fails++; $display("FAIL full_pop: got count=%0d ready=%b expected 15/1", bus.fifo_count, bus.skip_ready); end
        tests_run++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== exp_sum) begin fails++; $display("FAIL full_pop_sum: got %b/%h expected 1/%h", bus.sum_valid, bus.sum_out, exp_sum); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            bus.main_in = rand_vec();
            tick();
            tests_run++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== exp_sum) begin fails++; $display("FAIL drain_%0d: got %b/%h expected 1/%h", i, bus.sum_valid, bus.sum_out, exp_sum); end
        end
        bus.main_valid = 1'b0;
        tests_run++; if (bus.fifo_count !== '0 || bus.main_ready !== 1'b0) begin fails++; $display("FAIL drained: got count=%0d ready=%b expected 0/0", bus.fifo_count, bus.main_ready); end
        tick();
    endtask

    task automatic test_random();
        logic [VW-1:0] sv[40];
        logic [VW-1:0] mv[40];
        int si = 0, mi = 0, got = 0, cyc = 0;
        for (int i = 0; i < 40; i++) begin
            sv[i] = rand_vec();
            mv[i] = rand_vec();
        end
        bus.skip_valid = 1'b0;
        bus.main_valid = 1'b0;
        while (got < 40 && cyc < 3000) begin
            if (!bus.skip_valid && si < 40 && $urandom_range(0, 3) != 0) begin
                bus.skip_valid = 1'b1; bus.skip_in = sv[si];
            end
            if (!bus.main_valid && mi < 40 && $urandom_range(0, 1) != 0) begin
                bus.main_valid = 1'b1; bus.main_in = mv[mi];
            end
            tests_run++;
            if (bus.fifo_count !== 5'(skip_q.size()) || bus.skip_ready !== (skip_q.size() != DEPTH)
                || bus.main_ready !== (skip_q.size() != 0)) begin
                fails++;
                $display("FAIL rand_ctrl: got count=%0d sr=%b mr=%b expected count=%0d", bus.fifo_count, bus.skip_ready, bus.main_ready, skip_q.size());
            end
            tick();
            cyc++;
            if (last_push) begin si++; bus.skip_valid = 1'b0; end
            if (last_pop)  begin mi++; bus.main_valid = 1'b0; end
            tests_run++; if (bus.sum_valid !== exp_valid) begin fails++; $display("FAIL rand_valid: got %b expected %b", bus.sum_valid, exp_valid); end
            if (exp_valid) begin
                got++;
                tests_run++; if (bus.sum_out !== exp_sum) begin fails++; $display("FAIL rand_sum_%0d: got %h expected %h", got, bus.sum_out, exp_sum); end
            end
        end
        tests_run++; if (got != 40) begin fails++; $display("FAIL rand_timeout: got %0d results expected 40", got); end
        bus.skip_valid = 1'b0;
        bus.main_valid = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        bus.skip_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.skip_in = rand_vec();
            tick();
        end
        bus.skip_valid = 1'b0;
        bus.main_in = rand_vec(); bus.main_valid = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests_run++; if (bus.fifo_count !== '0 || bus.main_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_fifo: got count=%0d mr=%b expected 0/0", bus.fifo_count, bus.main_ready); end
        tests_run++; if (bus.sum_valid !== 1'b0 || bus.sum_out !== '0) begin fails++; $display("FAIL mid_reset_out: got %b/%h expected 0/0", bus.sum_valid, bus.sum_out); end
        bus.skip_in = rand_vec(); bus.skip_valid = 1'b1;
        tick();
        bus.skip_valid = 1'b0;
        tick();
        bus.main_valid = 1'b0;
        tests_run++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== exp_sum) begin fails++; $display("FAIL post_reset_sum: got %b/%h expected 1/%h", bus.sum_valid, bus.sum_out, exp_sum); end
        tick();
        tests_run++; if (bus.fifo_count !== '0) begin fails++; $display("FAIL post_reset_count: got %0d expected 0", bus.fifo_count); end
    endtask

    initial begin
        bus.skip_valid = 1'b0;
        bus.skip_in    = '0;
        bus.main_valid = 1'b0;
        bus.main_in    = '0;
        @(negedge clock);
        test_reset();
        test_single();
        test_extremes();
        test_main_before_skip();
        test_full();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
